// File: rtl/instruction_fetch.sv
// Instruction fetch stage: boot delay, sequential PC, redirect/flush and a
// one-entry output register handshaking with decode.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned BOOT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_misalign,
    output logic [31:0] fetch_count
);

    localparam int unsigned    CNT_W     = 4;
    localparam int unsigned    WADDR_W   = 30;
    localparam logic [31:0]    NOP_INSTR = 32'h0000_0013;
    localparam logic [WADDR_W-1:0] RESET_WPC = RESET_PC[31:2];
    localparam logic [CNT_W-1:0]   BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   boot_cnt_q, boot_cnt_d;
    logic [WADDR_W-1:0] pc_q, pc_d;
    logic               if_valid_q, if_valid_d;
    logic [31:0]        if_pc_q, if_pc_d;
    logic [31:0]        if_instr_q, if_instr_d;
    logic               if_misalign_q, if_misalign_d;
    logic [31:0]        fetch_count_q, fetch_count_d;

    logic handshake_c;
    logic load_c;

    // pc is kept as a word address so the byte address is aligned by construction
    assign imem_addr   = {pc_q, 2'b00};
    assign handshake_c = if_valid_q && if_ready;
    assign load_c      = (state_q == ST_RUN) && fetch_en && !redirect_valid
                         && (!if_valid_q || if_ready);

    always_comb begin
        state_d       = state_q;
        boot_cnt_d    = boot_cnt_q;
        pc_d          = pc_q;
        if_valid_d    = if_valid_q;
        if_pc_d       = if_pc_q;
        if_instr_d    = if_instr_q;
        if_misalign_d = 1'b0;
        fetch_count_d = fetch_count_q + (handshake_c ? 32'd1 : 32'd0);

        case (state_q)
            ST_BOOT: begin
                if_valid_d = 1'b0;
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d    = ST_RUN;
                    boot_cnt_d = '0;
                end else begin
                    boot_cnt_d = boot_cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!fetch_en && (!if_valid_q || if_ready)) begin
                    state_d = ST_HALT;
                end
                if (load_c) begin
                    if_pc_d    = {pc_q, 2'b00};
                    if_instr_d = imem_instr;
                    if_valid_d = 1'b1;
                    pc_d       = pc_q + WADDR_W'(1);
                end else if (handshake_c) begin
                    if_valid_d = 1'b0;
                end
            end
            ST_HALT: begin
                if (fetch_en) begin
                    state_d = ST_RUN;
                end
                if (handshake_c) begin
                    if_valid_d = 1'b0;
                end
            end
            default: begin
                state_d    = ST_BOOT;
                boot_cnt_d = '0;
                if_valid_d = 1'b0;
            end
        endcase

        // Redirect overrides any load or drain decided above and flushes the output
        if (redirect_valid) begin
            pc_d          = redirect_pc[31:2];
            if_valid_d    = 1'b0;
            if_misalign_d = |redirect_pc[1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            boot_cnt_q    <= '0;
            pc_q          <= RESET_WPC;
            if_valid_q    <= 1'b0;
            if_pc_q       <= '0;
            if_instr_q    <= NOP_INSTR;
            if_misalign_q <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            boot_cnt_q    <= boot_cnt_d;
            pc_q          <= pc_d;
            if_valid_q    <= if_valid_d;
            if_pc_q       <= if_pc_d;
            if_instr_q    <= if_instr_d;
            if_misalign_q <= if_misalign_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign if_valid    = if_valid_q;
    assign if_pc       = if_pc_q;
    assign if_instr    = if_instr_q;
    assign if_misalign = if_misalign_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; memory word[n] = n, handshakes are
// checked against a queue of expected fetch addresses.
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_misalign;
    logic [31:0] fetch_count;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    instruction_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_en      (fetch_en),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_pc         (if_pc),
        .if_instr      (if_instr),
        .if_misalign   (if_misalign),
        .fetch_count   (fetch_count)
    );

    assign imem_instr = {2'b00, imem_addr[31:2]};

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every handshake must match the oldest expected fetch
    always @(negedge clk) begin
        if (rst_n && if_valid && if_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_handshake_pc", if_pc, 32'hxxxx_xxxx);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("sb_pc", if_pc, e);
                chk("sb_instr", if_instr, {2'b00, e[31:2]});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        clk = 1'b0;
        rst_n = 1'b0;
        fetch_en = 1'b1;
        if_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_instr", if_instr, 32'h13);
        chk("rst_count", fetch_count, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_misalign", 32'(if_misalign), 32'd0);
        rst_n = 1'b1;

        // Boot delay then streaming
        step(); chk("boot1_valid", 32'(if_valid), 32'd0);
        step(); chk("boot2_valid", 32'(if_valid), 32'd0);
        step(); chk("first_valid", 32'(if_valid), 32'd1);
        chk("first_pc", if_pc, 32'h0);
        chk("first_instr", if_instr, 32'h0);
        step(); chk("stream_pc4", if_pc, 32'h4);
        step(); chk("stream_pc8", if_pc, 32'h8);
        step(); chk("count_after3", fetch_count, 32'd3);
        chk("stream_pc12", if_pc, 32'hC);

        // Back-pressure holds the output register and pc
        if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", if_pc, 32'hC);
            chk("stall_instr", if_instr, 32'h3);
            chk("stall_imem_addr", imem_addr, 32'h10);
            chk("stall_valid", 32'(if_valid), 32'd1);
        end
        chk("stall_count", fetch_count, 32'd3);
        exp_q.push_back(32'hC);
        exp_q.push_back(32'h10);
        if_ready = 1'b1;
        step(); chk("resume_pc16", if_pc, 32'h10);
        chk("resume_count4", fetch_count, 32'd4);
        step(); chk("resume_pc20", if_pc, 32'h14);
        chk("resume_count5", fetch_count, 32'd5);

        // Redirect while stalled: flush, no handshake counted
        if_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        step(); chk("redir_flush_valid", 32'(if_valid), 32'd0);
        chk("redir_count", fetch_count, 32'd5);
        chk("redir_imem_addr", imem_addr, 32'h40);
        redirect_valid = 1'b0;
        if_ready = 1'b1;
        exp_q.push_back(32'h40);
        step(); chk("redir_pc", if_pc, 32'h40);
        chk("redir_instr", if_instr, 32'h10);
        chk("redir_count_b", fetch_count, 32'd5);

        // Misaligned redirect with a concurrent handshake
        redirect_valid = 1'b1;
        redirect_pc = 32'h46;
        step(); chk("mis_pulse", 32'(if_misalign), 32'd1);
        chk("mis_valid", 32'(if_valid), 32'd0);
        chk("mis_count", fetch_count, 32'd6);
        chk("mis_imem_addr", imem_addr, 32'h44);
        redirect_valid = 1'b0;
        exp_q.push_back(32'h44);
        step(); chk("mis_clear", 32'(if_misalign), 32'd0);
        chk("mis_pc", if_pc, 32'h44);

        // Address wrap at the top of memory
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step(); chk("wrap_flush", 32'(if_valid), 32'd0);
        chk("wrap_aligned_nomis", 32'(if_misalign), 32'd0);
        chk("wrap_count", fetch_count, 32'd7);
        redirect_valid = 1'b0;
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0);
        step(); chk("wrap_top_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap_top_instr", if_instr, 32'h3FFF_FFFF);
        step(); chk("wrap_zero_pc", if_pc, 32'h0);
        chk("wrap_count8", fetch_count, 32'd8);

        // Halt after the pending handshake, then resume sequentially
        fetch_en = 1'b0;
        step(); chk("halt_valid", 32'(if_valid), 32'd0);
        chk("halt_count", fetch_count, 32'd9);
        chk("halt_imem_addr", imem_addr, 32'h4);
        step(); chk("halt_hold_valid", 32'(if_valid), 32'd0);
        chk("halt_hold_count", fetch_count, 32'd9);
        fetch_en = 1'b1;
        exp_q.push_back(32'h4);
        n = 0;
        while (!if_valid && n < 6) begin
            step();
            n++;
        end
        chk("resume_valid", 32'(if_valid), 32'd1);
        chk("resume_seq_pc", if_pc, 32'h4);
        step(); chk("resume_next_pc", if_pc, 32'h8);
        chk("resume_count10", fetch_count, 32'd10);
        if_ready = 1'b0;

        // Asynchronous reset mid-stream
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(if_valid), 32'd0);
        chk("async_rst_count", fetch_count, 32'd0);
        chk("async_rst_pc", if_pc, 32'h0);
        chk("async_rst_instr", if_instr, 32'h13);
        chk("async_rst_imem_addr", imem_addr, 32'h0);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC loaded on reset (word aligned; bits [1:0] ignored).
REQ-002 Parameter BOOT_CYCLES, default 2, cycles held in BOOT after reset release before the first fetch (range 1..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 fetch_en  input  1  when 0, no new fetch is accepted into the output register.
REQ-006 redirect_valid  input  1  branch/jump redirect request, sampled on the clock edge.
REQ-007 redirect_pc  input  32  redirect target byte address.
REQ-008 imem_addr  output  32  byte address driven to the combinational instruction memory.
REQ-009 imem_instr  input  32  instruction returned by memory in the same cycle for imem_addr.
REQ-010 if_valid  output  1  output register holds a valid instruction.
REQ-011 if_ready  input  1  decode stage accepts the instruction this cycle.
REQ-012 if_pc  output  32  byte address of the held instruction.
REQ-013 if_instr  output  32  held instruction word.
REQ-014 if_misalign  output  1  pulses one cycle when a redirect target had bits [1:0] != 0.
REQ-015 fetch_count  output  32  number of completed if_valid && if_ready handshakes.

Function
REQ-016 FSM states BOOT, RUN and HALT; reset enters BOOT.
REQ-017 BOOT counts BOOT_CYCLES edges with if_valid=0, then moves to RUN.
REQ-018 RUN moves to HALT when fetch_en=0 and if_valid=0 (or if_ready=1); HALT returns to RUN when fetch_en=1.
REQ-019 imem_addr equals the internal pc register combinationally, with bits [1:0] forced to 0.
REQ-020 Load condition: state RUN, fetch_en=1, no redirect, and (if_valid=0 or if_ready=1).
REQ-021 On a load, if_pc<=pc, if_instr<=imem_instr, if_valid<=1, and pc<=pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-022 If if_valid=1 and if_ready=0, if_pc, if_instr, if_valid and pc hold unchanged; no fetch is lost or duplicated.
REQ-023 If if_valid=1, if_ready=1 and the load condition is false, if_valid<=0 on that edge.
REQ-024 redirect_valid=1 has priority over every other event in RUN and HALT.
REQ-025 On redirect, pc<={redirect_pc[31:2],2'b00} and if_valid<=0 (flush), regardless of if_ready; the target is loaded no earlier than the next edge.
REQ-026 A redirect in BOOT is latched into pc; BOOT timing is unchanged.
REQ-027 if_misalign<=1 for exactly one cycle after a redirect with redirect_pc[1:0]!=0; otherwise 0.
REQ-028 fetch_count increments by 1 on each edge with if_valid=1 and if_ready=1, including the edge a redirect occurs; it wraps from 32'hFFFF_FFFF to 0.
REQ-029 Latency from a load to if_valid high is one clock; a back-to-back stream gives one instruction per cycle when if_ready stays 1.

Reset
REQ-030 rst_n=0 immediately (asynchronously) forces state=BOOT, pc=RESET_PC aligned, if_valid=0, if_pc=0, if_instr=32'h0000_0013 (NOP), if_misalign=0, fetch_count=0, boot counter=0.
REQ-031 Reset asserted mid-stream discards the held instruction; no partial update is visible after release.
REQ-032 Release of rst_n takes effect at the first rising clk edge after deassertion.

Verification
REQ-033 Reset with RESET_PC=0, BOOT_CYCLES=2, memory word[n]=n, if_ready=1 -> if_valid low for 2 cycles, then if_pc=0,4,8 with if_instr=0,1,2 on consecutive cycles; fetch_count=3 after the third handshake.
REQ-034 Hold if_ready=0 for 3 cycles while if_pc=4 -> if_pc=4 and if_instr=1 stable; imem_addr=8; resume gives if_pc=8 next without gaps.
REQ-035 redirect_valid=1 with redirect_pc=32'h40 while if_valid=1, if_ready=0 -> next cycle if_valid=0; the following cycle if_pc=32'h40; fetch_count unchanged.
REQ-036 redirect_pc=32'h46 -> if_misalign high for one cycle; the fetch proceeds at 32'h44.
REQ-037 Redirect to 32'hFFFF_FFFC with if_ready=1 -> if_pc=32'hFFFF_FFFC, then 32'h0000_0000.
REQ-038 fetch_en=0 mid-stream -> state HALT, if_valid drops after the pending handshake; fetch_en=1 resumes at the next sequential pc; rst_n pulse mid-stream -> if_valid=0 and fetch_count=0 immediately.
